rio_link_tx_framer: RTL and testbench
=====================================

RIO_LINK_TX_FRAMER -- requirements
Module: rio_link_tx_framer

Interface
REQ-001 SHALL have parameter RIO_COMMA_CHAR, default 8'hBC, comma K28.5, always placed in lane [7:0].
REQ-002 SHALL have parameter RIO_IDLE_DATA, default 8'h50, data byte paired with the comma in idle words.
REQ-003 SHALL have parameter RIO_CC_CHAR, default 8'hF7, K-char paired with the comma in clock-correction (CC) words.
REQ-004 SHALL have parameter ALIGN_LEN, default 16, number of idle words sent after reset, range 1..255.
REQ-005 SHALL have parameter CC_PERIOD, default 5000, cycles between CC bursts, range 2..65535.
REQ-006 SHALL have parameter CC_LEN, default 4, number of CC words per burst, range 1..15.
REQ-007 clk  input  1  single clock for all logic.
REQ-008 rst  input  1  synchronous, active-high reset.
REQ-009 i_tx_data  input  16  upstream word; [7:0] goes first on the line.
REQ-010 i_tx_isk  input  2  per-byte K flags for i_tx_data.
REQ-011 i_tx_valid  input  1  upstream word present.
REQ-012 o_tx_ready  output  1  block accepts i_tx_data in this cycle.
REQ-013 o_rio_tx_data  output  16  registered word to GTP TX.
REQ-014 o_rio_tx_isk  output  2  registered K flags to GTP TX.
REQ-015 o_err_misaligned  output  1  registered one-cycle pulse: a rejected lane-1 comma.

Function
REQ-016 Words: IDLE={RIO_IDLE_DATA,RIO_COMMA_CHAR} with isk 2'b01; CC={RIO_CC_CHAR,RIO_COMMA_CHAR} with isk 2'b11.
REQ-017 FSM states: ALIGN, DATA, CC.
REQ-018 ALIGN: emit IDLE for ALIGN_LEN cycles with o_tx_ready=0, then go to DATA.
REQ-019 Transfer occurs when i_tx_valid & o_tx_ready; the word appears on o_rio_tx_* exactly 1 cycle later (1-cycle latency).
REQ-020 o_tx_ready SHALL be 1 only in state DATA with cc_due=0, and SHALL depend only on registered state (no combinational path from i_tx_valid).
REQ-021 DATA with no transfer: emit IDLE.
REQ-022 Accepted word with i_tx_isk[1]=1 and i_tx_data[15:8]=RIO_COMMA_CHAR: emit IDLE instead, and pulse o_err_misaligned in the same output cycle.
REQ-023 Commas in lane [7:0] pass through unchanged.
REQ-024 CC counter is 16 bits; it increments every cycle outside CC, saturates at CC_PERIOD-1, and cc_due = (count == CC_PERIOD-1).
REQ-025 DATA with cc_due=1: emit one IDLE with ready=0, then go to CC.
REQ-026 CC: emit CC_LEN CC words with ready=0, then clear the counter to 0 and return to DATA.
REQ-027 cc_due reached during ALIGN: CC is taken immediately after ALIGN completes, through the REQ-025 path.
REQ-028 Upstream holding valid while ready=0 loses no data; the word is accepted once ready returns to 1.

Reset
REQ-029 On rst=1 at a clock edge: state=ALIGN, ALIGN count=0, CC counter=0, o_rio_tx_data=IDLE, o_rio_tx_isk=2'b01, o_err_misaligned=0.
REQ-030 o_tx_ready SHALL be 0 while rst=1.
REQ-031 rst asserted mid-CC or mid-DATA aborts the burst or stream; outputs show reset values on the next cycle.

Configuration
REQ-032 Macro RIO_TX_CC_EN defined: CC counter, CC state and REQ-024..REQ-027 are compiled in.
REQ-033 Macro RIO_TX_CC_EN undefined: no counter and no CC state; cc_due is constant 0; ready drops only during ALIGN and reset.

Verification (ALIGN_LEN=16, CC_PERIOD=64, CC_LEN=4)
REQ-034 Release rst with valid=0 -> 16 cycles of ready=0 with output 16'h50BC/2'b01; ready=1 from cycle 17; IDLE continues.
REQ-035 Stream 16'h1234/2'b00, 16'h5678/2'b00 with valid=1 -> same words on output, each 1 cycle after acceptance, in order.
REQ-036 Continuous valid under RIO_TX_CC_EN -> ready=0 for 5 cycles when count=63; outputs are 1x IDLE then 4x 16'hF7BC/2'b11; data resumes with no loss and the counter restarts at 0.
REQ-037 Accepted 16'hBC12/2'b10 -> output 16'h50BC/2'b01 with o_err_misaligned=1 for one cycle; an accepted 16'h12BC/2'b01 passes unchanged.
REQ-038 rst=1 during the 2nd CC word -> next cycle output 16'h50BC/2'b01 with ready=0; ALIGN restarts for 16 cycles.
REQ-039 RIO_TX_CC_EN undefined, 1000 cycles of continuous valid -> no F7BC word; ready stays 1 after ALIGN.

Source files
------------

// File: rtl/rio_link_tx_framer.sv
// Link-layer TX framer: sends alignment idles after reset, passes upstream words to the GTP TX,
// and inserts periodic clock-correction bursts when RIO_TX_CC_EN is defined.
module rio_link_tx_framer #(
  parameter logic [7:0]  RIO_COMMA_CHAR = 8'hBC,
  parameter logic [7:0]  RIO_IDLE_DATA  = 8'h50,
  parameter logic [7:0]  RIO_CC_CHAR    = 8'hF7,
  parameter int unsigned ALIGN_LEN      = 16,
  parameter int unsigned CC_PERIOD      = 5000,
  parameter int unsigned CC_LEN         = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] i_tx_data,
  input  logic [1:0]  i_tx_isk,
  input  logic        i_tx_valid,
  output logic        o_tx_ready,
  output logic [15:0] o_rio_tx_data,
  output logic [1:0]  o_rio_tx_isk,
  output logic        o_err_misaligned
);

  localparam logic [15:0] IdleWord  = {RIO_IDLE_DATA, RIO_COMMA_CHAR};
  localparam logic [7:0]  AlignLast = 8'(ALIGN_LEN - 1);

`ifdef RIO_TX_CC_EN
  typedef enum logic [1:0] {StAlign, StData, StCc} state_e;
  localparam logic [15:0] CcWord     = {RIO_CC_CHAR, RIO_COMMA_CHAR};
  localparam logic [7:0]  CcLast     = 8'(CC_LEN - 1);
  localparam logic [15:0] CcDueCount = 16'(CC_PERIOD - 1);
`else
  typedef enum logic [1:0] {StAlign, StData} state_e;
`endif

  state_e      state_q, state_d;
  logic [7:0]  len_cnt_q, len_cnt_d;
  logic [15:0] data_q, data_d;
  logic [1:0]  isk_q, isk_d;
  logic        err_q, err_d;
  logic        cc_due;
  logic        tx_fire;
  logic        lane1_comma;

`ifdef RIO_TX_CC_EN
  logic [15:0] cc_cnt_q, cc_cnt_d;

  assign cc_due = (cc_cnt_q == CcDueCount);

  // Counter freezes during the burst and is cleared on its last word.
  always_comb begin
    cc_cnt_d = cc_cnt_q;
    if (state_q == StCc) begin
      if (len_cnt_q == CcLast) begin
        cc_cnt_d = '0;
      end
    end else if (!cc_due) begin
      cc_cnt_d = cc_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cc_cnt_q <= '0;
    end else begin
      cc_cnt_q <= cc_cnt_d;
    end
  end
`else
  logic unused_cc_cfg;

  assign cc_due        = 1'b0;
  assign unused_cc_cfg = ^{RIO_CC_CHAR, 16'(CC_PERIOD), 8'(CC_LEN)};
`endif

  assign o_tx_ready  = (state_q == StData) && !cc_due && !rst;
  assign tx_fire     = i_tx_valid && o_tx_ready;
  assign lane1_comma = i_tx_isk[1] && (i_tx_data[15:8] == RIO_COMMA_CHAR);

  always_comb begin
    state_d   = state_q;
    len_cnt_d = len_cnt_q;
    data_d    = IdleWord;
    isk_d     = 2'b01;
    err_d     = 1'b0;
    case (state_q)
      StAlign: begin
        if (len_cnt_q == AlignLast) begin
          state_d   = StData;
          len_cnt_d = '0;
        end else begin
          len_cnt_d = len_cnt_q + 8'd1;
        end
      end
      StData: begin
`ifdef RIO_TX_CC_EN
        // The cycle spent here with cc_due set emits the single leading idle.
        if (cc_due) begin
          state_d   = StCc;
          len_cnt_d = '0;
        end
`endif
        if (tx_fire) begin
          if (lane1_comma) begin
            err_d = 1'b1;
          end else begin
            data_d = i_tx_data;
            isk_d  = i_tx_isk;
          end
        end
      end
`ifdef RIO_TX_CC_EN
      StCc: begin
        data_d = CcWord;
        isk_d  = 2'b11;
        if (len_cnt_q == CcLast) begin
          state_d   = StData;
          len_cnt_d = '0;
        end else begin
          len_cnt_d = len_cnt_q + 8'd1;
        end
      end
`endif
      default: begin
        state_d   = StAlign;
        len_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StAlign;
      len_cnt_q <= '0;
      data_q    <= IdleWord;
      isk_q     <= 2'b01;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_cnt_q <= len_cnt_d;
      data_q    <= data_d;
      isk_q     <= isk_d;
      err_q     <= err_d;
    end
  end

  assign o_rio_tx_data    = data_q;
  assign o_rio_tx_isk     = isk_q;
  assign o_err_misaligned = err_q;

endmodule

// File: tb/tb_rio_link_tx_framer.sv
// Self-checking bench for rio_link_tx_framer: directed vectors, CC corner sequences and
// random traffic against a queue-based reference model.
module tb_rio_link_tx_framer;

  localparam int ALIGN_LEN = 16;
  localparam int CC_PERIOD = 64;
  localparam int CC_LEN    = 4;
  localparam logic [15:0] IDLE_W = 16'h50BC;
  localparam logic [15:0] CC_W   = 16'hF7BC;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] i_tx_data = '0;
  logic [1:0]  i_tx_isk = '0;
  logic        i_tx_valid = 1'b0;
  logic        o_tx_ready;
  logic [15:0] o_rio_tx_data;
  logic [1:0]  o_rio_tx_isk;
  logic        o_err_misaligned;

  always #5 clk = ~clk;

  rio_link_tx_framer #(
    .RIO_COMMA_CHAR(8'hBC),
    .RIO_IDLE_DATA (8'h50),
    .RIO_CC_CHAR   (8'hF7),
    .ALIGN_LEN     (ALIGN_LEN),
    .CC_PERIOD     (CC_PERIOD),
    .CC_LEN        (CC_LEN)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .i_tx_data       (i_tx_data),
    .i_tx_isk        (i_tx_isk),
    .i_tx_valid      (i_tx_valid),
    .o_tx_ready      (o_tx_ready),
    .o_rio_tx_data   (o_rio_tx_data),
    .o_rio_tx_isk    (o_rio_tx_isk),
    .o_err_misaligned(o_err_misaligned)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: remaining alignment cycles, cycles since the last CC clear, and a queue of
  // words already scheduled for a clock-correction episode.
  int          align_left = ALIGN_LEN;
  int          age = 0;
  logic [15:0] q_data[$];
  logic [1:0]  q_isk[$];
  logic [15:0] exp_data;
  logic [1:0]  exp_isk;
  logic        exp_err;

  logic        obs_ready;
  logic [15:0] obs_data;
  logic [1:0]  obs_isk;
  logic        obs_err;

  typedef struct {
    logic        r;
    logic        v;
    logic [15:0] d;
    logic [1:0]  k;
    logic        er;
    logic [15:0] ed;
    logic [1:0]  ek;
    logic        ee;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic m_due();
`ifdef RIO_TX_CC_EN
    return age == CC_PERIOD - 1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic m_ready();
    return (align_left == 0) && (q_data.size() == 0) && !m_due();
  endfunction

  task automatic m_step(input logic r, input logic fire, input logic [15:0] d,
                        input logic [1:0] k);
    exp_data = IDLE_W;
    exp_isk  = 2'b01;
    exp_err  = 1'b0;
    if (r) begin
      align_left = ALIGN_LEN;
      age = 0;
      q_data.delete();
      q_isk.delete();
    end else if (align_left > 0) begin
      align_left--;
      if (age < CC_PERIOD - 1) age++;
    end else begin
      if (q_data.size() == 0 && m_due()) begin
        q_data.push_back(IDLE_W);
        q_isk.push_back(2'b01);
        for (int i = 0; i < CC_LEN; i++) begin
          q_data.push_back(CC_W);
          q_isk.push_back(2'b11);
        end
      end
      if (q_data.size() > 0) begin
        exp_data = q_data.pop_front();
        exp_isk  = q_isk.pop_front();
        if (exp_isk == 2'b11) begin
          if (q_data.size() == 0) age = 0;
        end else if (age < CC_PERIOD - 1) begin
          age++;
        end
      end else begin
        if (age < CC_PERIOD - 1) age++;
        if (fire) begin
          if (k[1] && d[15:8] == 8'hBC) begin
            exp_err = 1'b1;
          end else begin
            exp_data = d;
            exp_isk  = k;
          end
        end
      end
    end
  endtask

  // One clock: drive inputs, check ready before the edge, check outputs at the falling edge.
  task automatic step(input logic r, input logic v, input logic [15:0] d, input logic [1:0] k);
    logic mr;
    rst = r;
    i_tx_valid = v;
    i_tx_data = d;
    i_tx_isk = k;
    #1;
    mr = !r && m_ready();
    obs_ready = o_tx_ready;
    chk("ready", {15'd0, o_tx_ready}, {15'd0, mr});
    @(posedge clk);
    m_step(r, v && mr, d, k);
    @(negedge clk);
    obs_data = o_rio_tx_data;
    obs_isk  = o_rio_tx_isk;
    obs_err  = o_err_misaligned;
    chk("tx_data", obs_data, exp_data);
    chk("tx_isk", {14'd0, obs_isk}, {14'd0, exp_isk});
    chk("err_misaligned", {15'd0, obs_err}, {15'd0, exp_err});
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 16'h0000, 2'b00);
    step(1'b1, 1'b0, 16'h0000, 2'b00);
  endtask

  initial begin
    int          low;
    int          ncc;
    int          acc;
    int          rcv;
    logic        seen_high;
    logic        found;
    logic [15:0] nxt;
    logic [15:0] d;
    logic [1:0]  k;

    tbl[0] = '{1'b0, 1'b1, 16'h1234, 2'b00, 1'b1, 16'h1234, 2'b00, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 16'h5678, 2'b00, 1'b1, 16'h5678, 2'b00, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 16'hBC12, 2'b10, 1'b1, 16'h50BC, 2'b01, 1'b1};
    tbl[3] = '{1'b0, 1'b1, 16'h12BC, 2'b01, 1'b1, 16'h12BC, 2'b01, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 16'hAAAA, 2'b00, 1'b1, 16'h50BC, 2'b01, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 16'h00BC, 2'b11, 1'b1, 16'h00BC, 2'b11, 1'b0};
    tbl[6] = '{1'b0, 1'b1, 16'hBCBC, 2'b10, 1'b1, 16'h50BC, 2'b01, 1'b1};
    tbl[7] = '{1'b0, 1'b1, 16'hBC00, 2'b00, 1'b1, 16'hBC00, 2'b00, 1'b0};
    tbl[8] = '{1'b1, 1'b1, 16'h1111, 2'b00, 1'b0, 16'h50BC, 2'b01, 1'b0};

    // Alignment phase length after reset release.
    do_reset();
    low = 0;
    seen_high = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b0, 16'h0000, 2'b00);
      if (!obs_ready && !seen_high) low++;
      else seen_high = 1'b1;
      chk("align_idle", obs_data, IDLE_W);
    end
    chk("align_len", 16'(low), 16'd16);

    // Directed vectors: pass-through, lane-1 comma rejection, reset.
    for (int i = 0; i < 9; i++) begin
      step(tbl[i].r, tbl[i].v, tbl[i].d, tbl[i].k);
      chk("vec_ready", {15'd0, obs_ready}, {15'd0, tbl[i].er});
      chk("vec_data", obs_data, tbl[i].ed);
      chk("vec_isk", {14'd0, obs_isk}, {14'd0, tbl[i].ek});
      chk("vec_err", {15'd0, obs_err}, {15'd0, tbl[i].ee});
    end

`ifdef RIO_TX_CC_EN
    // Continuous valid across one CC burst: 5 stalled cycles, 4 CC words, no data lost.
    do_reset();
    for (int i = 0; i < ALIGN_LEN; i++) step(1'b0, 1'b0, 16'h0000, 2'b00);
    nxt = 16'h0100;
    acc = 0; rcv = 0; low = 0; ncc = 0;
    for (int i = 0; i < 100; i++) begin
      step(1'b0, 1'b1, nxt, 2'b00);
      if (obs_ready) begin
        acc++;
        nxt = nxt + 16'd1;
      end else begin
        low++;
      end
      if (obs_data == CC_W && obs_isk == 2'b11) begin
        ncc++;
      end else if (obs_data != IDLE_W) begin
        chk("cc_order", obs_data, 16'h0100 + 16'(rcv));
        rcv++;
      end
    end
    chk("cc_stall_cycles", 16'(low), 16'd5);
    chk("cc_word_count", 16'(ncc), 16'd4);
    chk("cc_no_loss", 16'(rcv), 16'(acc));

    // Reset during the second CC word restarts alignment.
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      step(1'b0, 1'b1, 16'h0200, 2'b00);
      if (obs_data == CC_W && obs_isk == 2'b11) found = 1'b1;
    end
    chk("cc_reached", {15'd0, found}, 16'd1);
    step(1'b1, 1'b1, 16'h0200, 2'b00);
    chk("rst_mid_cc_data", obs_data, IDLE_W);
    chk("rst_mid_cc_isk", {14'd0, obs_isk}, 16'd1);
    low = 0;
    seen_high = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b1, 16'h0300, 2'b00);
      if (!obs_ready && !seen_high) low++;
      else seen_high = 1'b1;
    end
    chk("realign_len", 16'(low), 16'd16);
`else
    // Without CC support: no CC words and no stalls after alignment.
    do_reset();
    for (int i = 0; i < ALIGN_LEN; i++) step(1'b0, 1'b0, 16'h0000, 2'b00);
    low = 0; ncc = 0;
    for (int i = 0; i < 1000; i++) begin
      d = 16'($urandom);
      k = 2'($urandom_range(0, 3));
      if (d == CC_W && k == 2'b11) k = 2'b00;
      step(1'b0, 1'b1, d, k);
      if (!obs_ready) low++;
      if (obs_data == CC_W && obs_isk == 2'b11) ncc++;
    end
    chk("nocc_stalls", 16'(low), 16'd0);
    chk("nocc_cc_words", 16'(ncc), 16'd0);
`endif

    // Random traffic with occasional resets and lane-1 commas.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      d = 16'($urandom);
      k = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) d[15:8] = 8'hBC;
      step(($urandom_range(0, 299) == 0), ($urandom_range(0, 3) != 0), d, k);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
